// File: rtl/jk_pkg.sv
// Shared definitions for the JK cell bank: mode encodings, cell drive
// encodings and the single-cell next-state rule.
package jk_pkg;

  // Front-end mode select
  localparam logic [1:0] JK_MODE_RAW = 2'b00;
  localparam logic [1:0] JK_MODE_UP  = 2'b01;
  localparam logic [1:0] JK_MODE_DN  = 2'b10;
  localparam logic [1:0] JK_MODE_LD  = 2'b11;

  // Cell drive encodings, written as {J,K}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Next state of one JK flip-flop given its present state and J/K drive
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      JK_HOLD: r = q;
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and asynchronous active-low reset.
// q_n is derived from the same register so it is always the exact complement.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  logic r_q;

  // Cell state: reset to RST_VAL, otherwise apply the JK rule when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= jk_next(r_q, j, k);
    end
  end

  assign q   = r_q;
  assign q_n = ~r_q;

endmodule

// File: rtl/jk_counter_bank.sv
// Bank of WIDTH JK cells with a mode-selected front end: raw per-bit J/K,
// synchronous up/down counter built from J=K toggle terms, or parallel load.
// Produces a combinational terminal count and a registered wrap pulse.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_n;
  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tc;
  logic             w_sat_hold;
  logic             r_wrap;

  // Toggle terms: bit i flips when every lower bit is 1 (up) or 0 (down)
  assign w_t_up[0] = 1'b1;
  assign w_t_dn[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
    assign w_t_up[gi] = &w_q[gi-1:0];
    assign w_t_dn[gi] = &w_q_n[gi-1:0];
  end

  // Terminal count: all-ones counting up, zero counting down
  always_comb begin
    w_tc = 1'b0;
    case (mode)
      JK_MODE_UP: w_tc = &w_q;
      JK_MODE_DN: w_tc = &w_q_n;
      default:    w_tc = 1'b0;
    endcase
  end

  // A saturating counter at its terminal count stops driving the cells
  assign w_sat_hold = (SATURATE != 0) && w_tc;

  // Mode mux: per-cell J/K drive, all-hold when disabled or saturated
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (en && !w_sat_hold) begin
      case (mode)
        JK_MODE_RAW: begin
          w_j = j;
          w_k = k;
        end
        JK_MODE_UP: begin
          w_j = w_t_up;
          w_k = w_t_up;
        end
        JK_MODE_DN: begin
          w_j = w_t_dn;
          w_k = w_t_dn;
        end
        default: begin
          w_j = d;
          w_k = ~d;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell #(
      .RST_VAL (RESET_VAL[gi])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .j     (w_j[gi]),
      .k     (w_k[gi]),
      .q     (w_q[gi]),
      .q_n   (w_q_n[gi])
    );
  end

  // Wrap pulse: one cycle after a non-saturating counter rolls over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= en && (SATURATE == 0) && w_tc;
    end
  end

  assign q    = w_q;
  assign q_n  = w_q_n;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_counter_bank.sv
// Testbench for jk_counter_bank: three instances (8-bit wrapping, 8-bit
// saturating with non-zero reset value, 1-bit wrapping) driven in lockstep,
// checked against a behavioural model through an expected-value queue.
module tb_jk_counter_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k, d;

  logic [7:0] q0, qn0, q1, qn1;
  logic [0:0] q2, qn2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0][7:0] q;
    logic [2:0]      tc;
    logic [2:0]      w;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq [3];
  int         mw [3] = '{8, 8, 1};
  bit         ms [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] mrst [3] = '{8'h00, 8'h5A, 8'h00};

  always #5 clk = ~clk;

  jk_counter_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q0), .q_n(qn0), .tc(tc0), .wrap(wr0));

  jk_counter_bank #(.WIDTH(8), .RESET_VAL(8'h5A), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q1), .q_n(qn1), .tc(tc1), .wrap(wr1));

  jk_counter_bank #(.WIDTH(1), .RESET_VAL(1'b0), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j[0:0]), .k(k[0:0]), .d(d[0:0]),
    .q(q2), .q_n(qn2), .tc(tc2), .wrap(wr2));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ones(input int w);
    return (w == 8) ? 8'hFF : 8'h01;
  endfunction

  // Behavioural model: returns {wrap, next q}
  function automatic logic [8:0] model_next(input logic [7:0] cq, input int w, input bit sat,
                                            input logic e, input logic [1:0] m,
                                            input logic [7:0] jj, input logic [7:0] kk,
                                            input logic [7:0] dd);
    logic [7:0] all1;
    all1 = ones(w);
    if (!e) return {1'b0, cq};
    case (m)
      2'b00: return {1'b0, ((jj & ~cq) | (~kk & cq)) & all1};
      2'b01: begin
        if (cq == all1) return sat ? {1'b0, cq} : {1'b1, 8'h00};
        return {1'b0, (cq + 8'd1) & all1};
      end
      2'b10: begin
        if (cq == 8'h00) return sat ? {1'b0, cq} : {1'b1, all1};
        return {1'b0, (cq - 8'd1) & all1};
      end
      default: return {1'b0, dd & all1};
    endcase
  endfunction

  function automatic logic tc_of(input logic [7:0] cq, input int w, input logic [1:0] m);
    if (m == 2'b01) return cq == ones(w);
    if (m == 2'b10) return cq == 8'h00;
    return 1'b0;
  endfunction

  // Drive one cycle of stimulus, queue the expected result, compare after the edge
  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] jj,
                      input logic [7:0] kk, input logic [7:0] dd);
    exp_t x, y;
    logic [8:0] r;
    logic [7:0] aq[3], aqn[3];
    logic       atc[3], aw[3];
    en = e; mode = m; j = jj; k = kk; d = dd;
    for (int i = 0; i < 3; i++) begin
      r = model_next(mq[i], mw[i], ms[i], e, m, jj, kk, dd);
      mq[i]   = r[7:0];
      x.q[i]  = r[7:0];
      x.w[i]  = r[8];
      x.tc[i] = tc_of(r[7:0], mw[i], m);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    aq  = '{q0, q1, {7'd0, q2}};
    aqn = '{qn0, qn1, {7'd0, qn2}};
    atc = '{tc0, tc1, tc2};
    aw  = '{wr0, wr1, wr2};
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("q[%0d]", i), aq[i], y.q[i]);
      check_eq($sformatf("q_n[%0d]", i), aqn[i], ~y.q[i] & ones(mw[i]));
      check_eq($sformatf("tc[%0d]", i), atc[i], y.tc[i]);
      check_eq($sformatf("wrap[%0d]", i), aw[i], y.w[i]);
    end
  endtask

  // Assert reset away from any clock edge and check its effect at once
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) mq[i] = mrst[i];
    check_eq({tag, "_q0"}, q0, 8'h00);
    check_eq({tag, "_qn0"}, qn0, 8'hFF);
    check_eq({tag, "_wr0"}, wr0, 1'b0);
    check_eq({tag, "_q1"}, q1, 8'h5A);
    check_eq({tag, "_qn1"}, qn1, 8'hA5);
    check_eq({tag, "_q2"}, q2, 1'b0);
    check_eq({tag, "_wr2"}, wr2, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
    for (int i = 0; i < 3; i++) mq[i] = mrst[i];

    // Reset without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_q0", q0, 8'h00);
    check_eq("rst_qn0", qn0, 8'hFF);
    check_eq("rst_wr0", wr0, 1'b0);
    check_eq("rst_q1", q1, 8'h5A);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Raw JK mode
    step(1'b1, 2'b00, 8'hF0, 8'h0F, 8'h00);
    check_eq("raw_set", q0, 8'hF0);
    step(1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00);
    check_eq("raw_tgl", q0, 8'h0F);
    step(1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    check_eq("raw_hold", q0, 8'h0F);

    // Load then count up through the wrap
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'hFE);
    check_eq("ld_fe", q0, 8'hFE);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("up_ff", q0, 8'hFF);
    check_eq("up_ff_tc", tc0, 1'b1);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("up_00", q0, 8'h00);
    check_eq("up_00_wrap", wr0, 1'b1);
    check_eq("sat_up_hold", q1, 8'hFF);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("up_01", q0, 8'h01);
    check_eq("up_01_wrap", wr0, 1'b0);

    // Saturating down count holds at zero
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'h01);
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h00);
    check_eq("sat_dn_00", q1, 8'h00);
    check_eq("sat_dn_tc", tc1, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b1, 2'b10, 8'h00, 8'h00, 8'h00);
    check_eq("sat_dn_hold", q1, 8'h00);
    check_eq("sat_dn_wrap", wr1, 1'b0);

    // Enable gating while counting up
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'h10);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("en1_11", q0, 8'h11);
    step(1'b0, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("en0_11", q0, 8'h11);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("en1_12", q0, 8'h12);

    // Reset while a wrap pulse is high
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'hFF);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("pre_rst_wrap", wr0, 1'b1);
    pulse_reset("rst_wrap");

    // Reset mid-count at 7F, then resume from reset value
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'h7E);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("cnt_7f", q0, 8'h7F);
    pulse_reset("rst_cnt");
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
    check_eq("resume0", q0, 8'h01);
    check_eq("resume1", q1, 8'h5B);

    // Random mixed traffic
    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
